// File: rtl/pulse_train_gen.sv
// pulse_train_gen: emits N high pulses of H cycles separated by L-cycle low gaps.
// Optional build macro PULSE_TRAIN_SELF_CHECK_EN adds an edge-counting checker
// that flags a mismatch between observed and reported rising edges.
module pulse_train_gen #(
    parameter int LEN_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [LEN_W-1:0] high_len,
    input  logic [LEN_W-1:0] low_len,
    input  logic [CNT_W-1:0] pulse_cnt,
    output logic             data_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] edges_sent,
    output logic             chk_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] EDGE_MAX = '1;

    state_t           state_reg, state_next;
    logic [LEN_W-1:0] phase_reg, phase_next;
    logic [LEN_W-1:0] high_reg,  high_next;
    logic [LEN_W-1:0] low_reg,   low_next;
    logic [CNT_W-1:0] num_reg,   num_next;
    logic [CNT_W-1:0] edges_reg, edges_next;
    logic             done_reg,  done_next;
    logic             data_out_reg;
    logic             accept;

    // A command is taken only from IDLE; abort always beats a simultaneous start.
    assign accept = (state_reg == IDLE) && start && !abort;

    // Next-state, phase counting and latching of the train parameters.
    always_comb begin
        state_next = state_reg;
        phase_next = phase_reg;
        high_next  = high_reg;
        low_next   = low_reg;
        num_next   = num_reg;
        edges_next = edges_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (pulse_cnt == '0) begin
                        // Empty train: report completion straight away.
                        done_next  = 1'b1;
                        edges_next = '0;
                    end else begin
                        // Zero lengths are promoted to one cycle.
                        high_next  = (high_len == '0) ? LEN_W'(1) : high_len;
                        low_next   = (low_len  == '0) ? LEN_W'(1) : low_len;
                        num_next   = pulse_cnt;
                        edges_next = CNT_W'(1);
                        phase_next = high_next - LEN_W'(1);
                        state_next = HIGH;
                    end
                end
            end
            HIGH: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (phase_reg != '0) begin
                    phase_next = phase_reg - LEN_W'(1);
                end else if (edges_reg >= num_reg) begin
                    // Last pulse ends the train with no trailing low phase.
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else begin
                    state_next = LOW;
                    phase_next = low_reg - LEN_W'(1);
                end
            end
            LOW: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (phase_reg != '0) begin
                    phase_next = phase_reg - LEN_W'(1);
                end else begin
                    state_next = HIGH;
                    phase_next = high_reg - LEN_W'(1);
                    if (edges_reg != EDGE_MAX) begin
                        edges_next = edges_reg + CNT_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and datapath registers; data_out is registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            phase_reg    <= '0;
            high_reg     <= '0;
            low_reg      <= '0;
            num_reg      <= '0;
            edges_reg    <= '0;
            done_reg     <= 1'b0;
            data_out_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            phase_reg    <= phase_next;
            high_reg     <= high_next;
            low_reg      <= low_next;
            num_reg      <= num_next;
            edges_reg    <= edges_next;
            done_reg     <= done_next;
            data_out_reg <= (state_next == HIGH);
        end
    end

    assign data_out   = data_out_reg;
    assign busy       = (state_reg != IDLE);
    assign done       = done_reg;
    assign edges_sent = edges_reg;

`ifdef PULSE_TRAIN_SELF_CHECK_EN
    logic             prev_reg;
    logic [CNT_W-1:0] det_reg;
    logic             err_reg;
    logic             rise;

    // Observes the actual output line, not the FSM, so corruption is caught.
    assign rise = data_out_reg & ~prev_reg;

    // Count observed rising edges and compare against edges_sent at completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_reg <= 1'b0;
            det_reg  <= '0;
            err_reg  <= 1'b0;
        end else begin
            prev_reg <= data_out_reg;
            if (accept) begin
                det_reg <= '0;
            end else if (rise && (det_reg != EDGE_MAX)) begin
                det_reg <= det_reg + CNT_W'(1);
            end
            if (done_reg && (det_reg != edges_reg)) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign chk_err = err_reg;
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_train_gen.sv
// Bench for pulse_train_gen: expected waveforms come from a per-train model
// that lists the output values cycle by cycle from H, L and N.
module tb_pulse_train_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] high_len = '0;
    logic [7:0] low_len = '0;
    logic [7:0] pulse_cnt = '0;
    logic       data_out, busy, done, chk_err;
    logic [7:0] edges_sent;

    int compared = 0;
    int mismatched = 0;

    pulse_train_gen #(.LEN_W(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .high_len(high_len), .low_len(low_len), .pulse_cnt(pulse_cnt),
        .data_out(data_out), .busy(busy), .done(done),
        .edges_sent(edges_sent), .chk_err(chk_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       d;
        logic       b;
        logic       dn;
        logic [7:0] e;
    } exp_t;

    exp_t exp_q[$];

    // Expected outputs for cycles 1.. after an accepted start: pulses, gaps,
    // the done cycle and one quiet cycle after it.
    function automatic void build_model(input int h, input int l, input int n);
        int hh = (h == 0) ? 1 : h;
        int ll = (l == 0) ? 1 : l;
        int rises = 0;
        exp_q.delete();
        for (int p = 0; p < n; p++) begin
            rises++;
            for (int c = 0; c < hh; c++) exp_q.push_back('{1'b1, 1'b1, 1'b0, 8'(rises)});
            if (p < n - 1)
                for (int c = 0; c < ll; c++) exp_q.push_back('{1'b0, 1'b1, 1'b0, 8'(rises)});
        end
        exp_q.push_back('{1'b0, 1'b0, 1'b1, 8'(rises)});
        exp_q.push_back('{1'b0, 1'b0, 1'b0, 8'(rises)});
    endfunction

    // Present a start for one edge; returns at the negedge of cycle 1.
    task automatic kick(input int h, input int l, input int n);
        high_len  = 8'(h);
        low_len   = 8'(l);
        pulse_cnt = 8'(n);
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        compared++;
        if ({data_out, busy, done, edges_sent, chk_err} !== 12'h0) begin
            mismatched++;
            $display("FAIL reset_hold got d=%b b=%b dn=%b e=%0d err=%b want all 0",
                     data_out, busy, done, edges_sent, chk_err);
        end
        rst_n = 1'b1;
        @(negedge clk);
        compared++;
        if ({data_out, busy, done, edges_sent, chk_err} !== 12'h0) begin
            mismatched++;
            $display("FAIL reset_idle got d=%b b=%b dn=%b e=%0d err=%b want all 0",
                     data_out, busy, done, edges_sent, chk_err);
        end
        // Reset in the middle of a train clears everything immediately.
        kick(4, 4, 3);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if ({data_out, busy, done, edges_sent} !== 11'h0) begin
            mismatched++;
            $display("FAIL reset_async got d=%b b=%b dn=%b e=%0d want all 0",
                     data_out, busy, done, edges_sent);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            compared++;
            if ({data_out, busy, done} !== 3'b000) begin
                mismatched++;
                $display("FAIL reset_no_done cyc=%0d got d=%b b=%b dn=%b want 000",
                         i, data_out, busy, done);
            end
        end
        $display("reset: checked hold, idle and mid-train reset");
    endtask

    task automatic test_basic();
        int nbusy = 0;
        int done_cyc = 0;
        build_model(3, 2, 4);
        kick(3, 2, 4);
        foreach (exp_q[i]) begin
            compared++;
            if ({data_out, busy, done, edges_sent} !== {exp_q[i].d, exp_q[i].b, exp_q[i].dn, exp_q[i].e}) begin
                mismatched++;
                $display("FAIL basic cyc=%0d got d=%b b=%b dn=%b e=%0d want d=%b b=%b dn=%b e=%0d",
                         i + 1, data_out, busy, done, edges_sent,
                         exp_q[i].d, exp_q[i].b, exp_q[i].dn, exp_q[i].e);
            end
            if (busy) nbusy++;
            if (done) done_cyc = i + 1;
            @(negedge clk);
        end
        compared++;
        if (nbusy != 18) begin
            mismatched++;
            $display("FAIL basic_busy_len got %0d want 18", nbusy);
        end
        compared++;
        if (done_cyc != 19) begin
            mismatched++;
            $display("FAIL basic_done_cycle got %0d want 19", done_cyc);
        end
        compared++;
        if (chk_err !== 1'b0) begin
            mismatched++;
            $display("FAIL basic_chk_err got %b want 0", chk_err);
        end
        $display("train h=3 l=2 n=4: busy=%0d done_cycle=%0d", nbusy, done_cyc);
    endtask

    task automatic test_min_len();
        build_model(0, 0, 2);
        kick(0, 0, 2);
        foreach (exp_q[i]) begin
            compared++;
            if ({data_out, busy, done, edges_sent} !== {exp_q[i].d, exp_q[i].b, exp_q[i].dn, exp_q[i].e}) begin
                mismatched++;
                $display("FAIL min_len cyc=%0d got d=%b b=%b dn=%b e=%0d want d=%b b=%b dn=%b e=%0d",
                         i + 1, data_out, busy, done, edges_sent,
                         exp_q[i].d, exp_q[i].b, exp_q[i].dn, exp_q[i].e);
            end
            @(negedge clk);
        end
        $display("train h=0 l=0 n=2: %0d cycles checked", exp_q.size());
    endtask

    task automatic test_zero_count();
        build_model(5, 5, 0);
        kick(5, 5, 0);
        foreach (exp_q[i]) begin
            compared++;
            if ({data_out, busy, done, edges_sent} !== {exp_q[i].d, exp_q[i].b, exp_q[i].dn, exp_q[i].e}) begin
                mismatched++;
                $display("FAIL zero_count cyc=%0d got d=%b b=%b dn=%b e=%0d want d=%b b=%b dn=%b e=%0d",
                         i + 1, data_out, busy, done, edges_sent,
                         exp_q[i].d, exp_q[i].b, exp_q[i].dn, exp_q[i].e);
            end
            @(negedge clk);
        end
        $display("train n=0: %0d cycles checked", exp_q.size());
    endtask

    task automatic test_abort();
        build_model(5, 5, 3);
        kick(5, 5, 3);
        for (int i = 0; i < 8; i++) begin
            compared++;
            if ({data_out, busy, done, edges_sent} !== {exp_q[i].d, exp_q[i].b, exp_q[i].dn, exp_q[i].e}) begin
                mismatched++;
                $display("FAIL abort_pre cyc=%0d got d=%b b=%b dn=%b e=%0d want d=%b b=%b dn=%b e=%0d",
                         i + 1, data_out, busy, done, edges_sent,
                         exp_q[i].d, exp_q[i].b, exp_q[i].dn, exp_q[i].e);
            end
            if (i == 7) abort = 1'b1;
            @(negedge clk);
        end
        abort = 1'b0;
        for (int i = 0; i < 5; i++) begin
            compared++;
            if ({data_out, busy, done, edges_sent} !== {3'b000, 8'd1}) begin
                mismatched++;
                $display("FAIL abort_post cyc=%0d got d=%b b=%b dn=%b e=%0d want d=0 b=0 dn=0 e=1",
                         i, data_out, busy, done, edges_sent);
            end
            @(negedge clk);
        end
        // Abort together with start in IDLE drops the start.
        pulse_cnt = 8'd2;
        high_len  = 8'd1;
        low_len   = 8'd1;
        start     = 1'b1;
        abort     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            compared++;
            if ({data_out, busy, done, edges_sent} !== {3'b000, 8'd1}) begin
                mismatched++;
                $display("FAIL abort_start cyc=%0d got d=%b b=%b dn=%b e=%0d want d=0 b=0 dn=0 e=1",
                         i, data_out, busy, done, edges_sent);
            end
            @(negedge clk);
        end
        $display("abort: train h=5 l=5 n=3 cancelled in cycle 8, start+abort dropped");
    endtask

    task automatic test_ignore_start();
        build_model(3, 2, 4);
        kick(3, 2, 4);
        foreach (exp_q[i]) begin
            compared++;
            if ({data_out, busy, done, edges_sent} !== {exp_q[i].d, exp_q[i].b, exp_q[i].dn, exp_q[i].e}) begin
                mismatched++;
                $display("FAIL ignore_start cyc=%0d got d=%b b=%b dn=%b e=%0d want d=%b b=%b dn=%b e=%0d",
                         i + 1, data_out, busy, done, edges_sent,
                         exp_q[i].d, exp_q[i].b, exp_q[i].dn, exp_q[i].e);
            end
            if (i == 2 || i == 5 || i == 12) begin
                high_len  = 8'($urandom_range(1, 9));
                low_len   = 8'($urandom_range(1, 9));
                pulse_cnt = 8'($urandom_range(1, 9));
                start     = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        $display("train h=3 l=2 n=4 with mid-train starts: %0d cycles checked", exp_q.size());
    endtask

    task automatic test_back_to_back();
        build_model(2, 1, 2);
        kick(2, 1, 2);
        for (int i = 0; i < exp_q.size() - 1; i++) begin
            compared++;
            if ({data_out, busy, done, edges_sent} !== {exp_q[i].d, exp_q[i].b, exp_q[i].dn, exp_q[i].e}) begin
                mismatched++;
                $display("FAIL b2b_first cyc=%0d got d=%b b=%b dn=%b e=%0d want d=%b b=%b dn=%b e=%0d",
                         i + 1, data_out, busy, done, edges_sent,
                         exp_q[i].d, exp_q[i].b, exp_q[i].dn, exp_q[i].e);
            end
            if (i < exp_q.size() - 2) @(negedge clk);
        end
        // Now in the done cycle: launch the next train.
        kick(1, 1, 1);
        build_model(1, 1, 1);
        foreach (exp_q[i]) begin
            compared++;
            if ({data_out, busy, done, edges_sent} !== {exp_q[i].d, exp_q[i].b, exp_q[i].dn, exp_q[i].e}) begin
                mismatched++;
                $display("FAIL b2b_second cyc=%0d got d=%b b=%b dn=%b e=%0d want d=%b b=%b dn=%b e=%0d",
                         i + 1, data_out, busy, done, edges_sent,
                         exp_q[i].d, exp_q[i].b, exp_q[i].dn, exp_q[i].e);
            end
            @(negedge clk);
        end
        $display("back-to-back: h=2 l=1 n=2 then h=1 l=1 n=1");
    endtask

    task automatic test_random();
        for (int t = 0; t < 16; t++) begin
            int h = $urandom_range(0, 6);
            int l = $urandom_range(0, 6);
            int n = $urandom_range(0, 5);
            int bad = 0;
            build_model(h, l, n);
            kick(h, l, n);
            foreach (exp_q[i]) begin
                compared++;
                if ({data_out, busy, done, edges_sent} !== {exp_q[i].d, exp_q[i].b, exp_q[i].dn, exp_q[i].e}) begin
                    mismatched++;
                    bad++;
                    $display("FAIL random t=%0d cyc=%0d got d=%b b=%b dn=%b e=%0d want d=%b b=%b dn=%b e=%0d",
                             t, i + 1, data_out, busy, done, edges_sent,
                             exp_q[i].d, exp_q[i].b, exp_q[i].dn, exp_q[i].e);
                end
                @(negedge clk);
            end
            $display("random train %0d h=%0d l=%0d n=%0d cycles=%0d bad=%0d", t, h, l, n, exp_q.size(), bad);
        end
    endtask

`ifdef PULSE_TRAIN_SELF_CHECK_EN
    task automatic test_self_check();
        int waited = 0;
        build_model(3, 2, 4);
        kick(3, 2, 4);
        repeat (exp_q.size()) @(negedge clk);
        compared++;
        if (chk_err !== 1'b0) begin
            mismatched++;
            $display("FAIL chk_clean got %b want 0", chk_err);
        end
        kick(5, 2, 3);
        @(negedge clk);
        force dut.data_out_reg = 1'b0;
        @(negedge clk);
        release dut.data_out_reg;
        while (!done && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        compared++;
        if (!done) begin
            mismatched++;
            $display("FAIL chk_wait_done got timeout want done within 60 cycles");
        end
        @(negedge clk);
        compared++;
        if (chk_err !== 1'b1) begin
            mismatched++;
            $display("FAIL chk_detect got %b want 1", chk_err);
        end
        build_model(1, 1, 1);
        kick(1, 1, 1);
        repeat (exp_q.size()) @(negedge clk);
        compared++;
        if (chk_err !== 1'b1) begin
            mismatched++;
            $display("FAIL chk_sticky got %b want 1", chk_err);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        compared++;
        if (chk_err !== 1'b0) begin
            mismatched++;
            $display("FAIL chk_reset got %b want 0", chk_err);
        end
        $display("self-check: clean train, corrupted train, sticky and reset");
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_min_len();
        test_zero_count();
        test_abort();
        test_ignore_start();
        test_back_to_back();
        test_random();
`ifdef PULSE_TRAIN_SELF_CHECK_EN
        test_self_check();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
